serial_adder: RTL and testbench

Bit-serial adder that accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake. It adds them LSB-first through a single one-bit full-adder cell, one bit per clock, and keeps the carry in a register between bits. It returns the WIDTH-bit sum and carry-out over a second valid/ready handshake. It is the sequential wrapper directly around the team's one-bit full-adder cell: it feeds the cell's a/b/c inputs and consumes its sum/cout outputs.

---
 rtl/serial_adder_pkg.sv | 11 +
 rtl/serial_adder_fa_cell.sv | 13 +
 rtl/serial_adder.sv | 102 ++++++++++
 tb/tb_serial_adder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing rules for the bit-serial adder.
package serial_adder_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} sa_state_t;

   // The bit counter must be able to hold values 0..WIDTH.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Combinational one-bit full adder used as the serial adder's datapath cell.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ c;
   assign cout = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB-first through one full-adder
// cell, one bit per clock, with valid/ready handshakes on input and output.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int               CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   sa_state_t        state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic [WIDTH-1:0] res_nxt;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic             s;
   logic             co;

   fa_cell u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .c    (carry),
      .sum  (s),
      .cout (co)
   );

   // A one-bit result register has no upper slice to shift down.
   generate
      if (WIDTH == 1) begin : g_res_w1
         assign res_nxt = s;
      end else begin : g_res_wn
         assign res_nxt = {s, res_sr[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         res_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  carry <= cin;
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               res_sr <= res_nxt;
               carry  <= co;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Operand shifters carry no state that matters outside SHIFT, so they skip reset.
   always_ff @(posedge clk) begin
      if (state == IDLE && in_valid) begin
         a_sr <= a;
         b_sr <= b;
      end else if (state == SHIFT) begin
         a_sr <= a_sr >> 1;
         b_sr <= b_sr >> 1;
      end
   end

   assign in_ready  = (state == IDLE) && !rst;
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign sum       = res_sr;
   assign cout      = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8, plus a WIDTH=1 build.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
   logic [7:0] a, b, sum;

   logic       in1_valid, in1_ready, out1_valid, out1_ready, cin1, cout1, busy1;
   logic [0:0] a1, b1, sum1;

   int ntests = 0;
   int nfail  = 0;
   int cyc    = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] s;
      logic       co;
   } vec_t;

   vec_t vecs[10];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_adder #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .busy(busy)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in1_valid), .in_ready(in1_ready),
      .a(a1), .b(b1), .cin(cin1), .out_valid(out1_valid), .out_ready(out1_ready),
      .sum(sum1), .cout(cout1), .busy(busy1)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One operation on the WIDTH=8 instance; hold = cycles of back-pressure in DONE.
   task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                        input int hold, output logic [7:0] rs, output logic rc, output int lat);
      int   w;
      logic bad;
      w = 0;
      while (!in_ready && w < 50) begin step(); w++; end
      check("in_ready_before_op", in_ready, 1);
      a = ia; b = ib; cin = ic; in_valid = 1'b1; out_ready = 1'b0;
      step();
      in_valid = 1'b0; a = ~ia; b = ~ib; cin = ~ic;
      lat = 0; bad = 1'b0;
      while (!out_valid && lat < 50) begin
         if (!busy || in_ready) bad = 1'b1;
         step();
         lat++;
      end
      check("busy_during_op", bad, 0);
      rs = sum; rc = cout;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; a = 8'h11; b = 8'h22;
         step();
         in_valid = 1'b0;
         check("hold_stable", {out_valid, in_ready, busy, rc, rs}, {1'b1, 1'b0, 1'b1, rc, rs});
         check("hold_value", {sum, cout}, {rs, rc});
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("released", {out_valid, in_ready, busy}, 3'b010);
   endtask

   initial begin
      logic [7:0] rs, ea, eb;
      logic       rc, ec, seen;
      logic [8:0] exp9;
      int         lat, w, t, prev;

      vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
      vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
      vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
      vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
      vecs[7] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
      vecs[8] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
      vecs[9] = '{8'h01, 8'h02, 1'b1, 8'h04, 1'b0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
      in1_valid = 1'b0; out1_ready = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
      repeat (3) step();
      check("reset_state", {in_ready, out_valid, busy, cout, sum}, 12'h000);
      check("reset_state_w1", {in1_ready, out1_valid, busy1, cout1, sum1}, 5'h00);
      rst = 1'b0;
      #1;
      check("in_ready_after_rst", in_ready, 1);
      check("in_ready_after_rst_w1", in1_ready, 1);

      foreach (vecs[i]) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].cin, 0, rs, rc, lat);
         check("vec_sum", rs, vecs[i].s);
         check("vec_cout", rc, vecs[i].co);
         check("vec_latency", lat, 8);
      end

      // Back-pressure for five cycles with in_valid noise
      do_op(8'h5A, 8'h3C, 1'b0, 5, rs, rc, lat);
      check("bp_sum", rs, 8'h96);
      check("bp_cout", rc, 0);
      check("bp_latency", lat, 8);

      // Reset three SHIFT cycles into an operation
      a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      #1;
      check("in_ready_in_rst", in_ready, 0);
      step();
      rst = 1'b0;
      #1;
      check("abort_state", {out_valid, busy, in_ready, cout, sum}, {3'b001, 1'b0, 8'h00});
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (out_valid || busy) seen = 1'b1;
      end
      check("abort_no_out_valid", seen, 0);
      do_op(8'h12, 8'h34, 1'b0, 0, rs, rc, lat);
      check("post_abort_sum", {rc, rs}, 9'h046);

      // Back-to-back random operations with out_ready tied high
      out_ready = 1'b1;
      ea = 8'($urandom); eb = 8'($urandom); ec = 1'($urandom);
      a = ea; b = eb; cin = ec; in_valid = 1'b1;
      prev = 0;
      for (int i = 0; i < 1000; i++) begin
         w = 0;
         while (!in_ready && w < 20) begin step(); w++; end
         if (w >= 20) begin
            check("b2b_in_ready_timeout", w, 0);
            break;
         end
         step();
         t = cyc;
         if (i > 0) check("b2b_interval", t - prev, 10);
         prev = t;
         exp9 = {1'b0, ea} + {1'b0, eb} + {8'h00, ec};
         a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
         w = 0;
         while (!out_valid && w < 20) begin step(); w++; end
         check("b2b_result", {cout, sum}, exp9);
         ea = 8'($urandom); eb = 8'($urandom); ec = 1'($urandom);
         a = ea; b = eb; cin = ec;
      end
      in_valid = 1'b0;
      repeat (12) step();
      out_ready = 1'b0;

      // WIDTH=1 build: 1+1+1
      a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; in1_valid = 1'b1;
      step();
      in1_valid = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
      lat = 0;
      while (!out1_valid && lat < 20) begin step(); lat++; end
      check("w1_latency", lat, 1);
      check("w1_result", {cout1, sum1}, 2'b11);
      out1_ready = 1'b1;
      step();
      out1_ready = 1'b0;
      check("w1_released", {out1_valid, in1_ready}, 2'b01);
      // 1+0+0
      a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0; in1_valid = 1'b1;
      step();
      in1_valid = 1'b0;
      lat = 0;
      while (!out1_valid && lat < 20) begin step(); lat++; end
      check("w1_result2", {cout1, sum1}, 2'b01);
      out1_ready = 1'b1;
      step();
      out1_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
